// File: rtl/enemy_contact_attack.sv
// enemy_contact_attack: body-contact damage, wind-up, invulnerability cooldown and game over.
// Optional passive regeneration when PLAYER_REGEN_EN is defined.
module enemy_contact_attack #(
  parameter int PLAYER_W = 26,
  parameter int PLAYER_H = 26,
  parameter int ENEMY_W = 26,
  parameter int ENEMY_H = 26,
  parameter int MAX_BLOOD = 100,
  parameter int DAMAGE = 10,
  parameter int WINDUP_FRAMES = 2,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [8:0] Player_X,
  input  logic [8:0] Player_Y,
  input  logic [8:0] Enemy_X,
  input  logic [8:0] Enemy_Y,
  input  logic       Enemy_Alive,
  output logic [6:0] Player_Blood,
  output logic       Player_Hurt,
  output logic       Game_Over,
  output logic [7:0] Hit_Count
);
  typedef enum logic [1:0] {ALIVE, COOLDOWN, DEAD} state_t;
  state_t state;
  logic frame_clk_d, tick, contact;
  logic [15:0] contact_cnt, cool_cnt;
  logic [6:0] blood_hit;
`ifdef PLAYER_REGEN_EN
  localparam int REGEN_FRAMES = 60;
  logic [5:0] regen_cnt;
`endif
  // Widened to 10 bits so box right/bottom edges never wrap.
  assign contact = Enemy_Alive
    & ({1'b0, Enemy_X} < {1'b0, Player_X} + 10'(PLAYER_W))
    & ({1'b0, Player_X} < {1'b0, Enemy_X} + 10'(ENEMY_W))
    & ({1'b0, Enemy_Y} < {1'b0, Player_Y} + 10'(PLAYER_H))
    & ({1'b0, Player_Y} < {1'b0, Enemy_Y} + 10'(ENEMY_H));
  assign blood_hit = (Player_Blood <= 7'(DAMAGE)) ? 7'd0 : Player_Blood - 7'(DAMAGE);
  assign Player_Hurt = state == COOLDOWN;
  assign Game_Over = state == DEAD;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_d <= 1'b0;
      tick <= 1'b0;
      state <= ALIVE;
      contact_cnt <= '0;
      cool_cnt <= '0;
      Player_Blood <= 7'(MAX_BLOOD);
      Hit_Count <= '0;
`ifdef PLAYER_REGEN_EN
      regen_cnt <= '0;
`endif
    end else begin
      frame_clk_d <= frame_clk;
      tick <= frame_clk & ~frame_clk_d;
      if (tick) begin
        case (state)
          ALIVE: begin
            if (!contact)
              contact_cnt <= '0;
            else if (contact_cnt + 16'd1 < 16'(WINDUP_FRAMES))
              contact_cnt <= contact_cnt + 16'd1;
            else begin
              Player_Blood <= blood_hit;
              Hit_Count <= Hit_Count + {7'd0, Hit_Count != 8'hFF};
              contact_cnt <= '0;
              cool_cnt <= '0;
              state <= (blood_hit == 7'd0) ? DEAD : COOLDOWN;
            end
`ifdef PLAYER_REGEN_EN
            if (contact || Player_Blood >= 7'(MAX_BLOOD))
              regen_cnt <= '0;
            else if (regen_cnt == 6'(REGEN_FRAMES - 1)) begin
              regen_cnt <= '0;
              Player_Blood <= Player_Blood + 7'd1;
            end else
              regen_cnt <= regen_cnt + 6'd1;
`endif
          end
          COOLDOWN: begin
            contact_cnt <= '0;
            cool_cnt <= cool_cnt + 16'd1;
            if (cool_cnt == 16'(COOLDOWN_FRAMES - 1)) state <= ALIVE;
`ifdef PLAYER_REGEN_EN
            regen_cnt <= '0;
`endif
          end
          default: begin
            Player_Blood <= '0;
`ifdef PLAYER_REGEN_EN
            regen_cnt <= '0;
`endif
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_enemy_contact_attack.sv
// tb_enemy_contact_attack: directed and randomized scenarios against a per-frame game model.
module tb_enemy_contact_attack;
  localparam int PW = 26, PH = 26, EW = 26, EH = 26;
  logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, Enemy_Alive = 1'b0;
  logic [8:0] Player_X = '0, Player_Y = '0, Enemy_X = '0, Enemy_Y = '0;
  logic [6:0] Player_Blood;
  logic Player_Hurt, Game_Over;
  logic [7:0] Hit_Count;
  int checks = 0, passed = 0;
  int m_blood = 100, m_hits = 0, m_cool = 0, m_streak = 0, m_regen = 0;
  bit m_dead = 0;

  enemy_contact_attack dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .Player_X(Player_X), .Player_Y(Player_Y), .Enemy_X(Enemy_X), .Enemy_Y(Enemy_Y),
    .Enemy_Alive(Enemy_Alive), .Player_Blood(Player_Blood), .Player_Hurt(Player_Hurt),
    .Game_Over(Game_Over), .Hit_Count(Hit_Count)
  );

  always #5 Clk = ~Clk;

  function automatic bit ref_contact();
    return Enemy_Alive && int'(Enemy_X) < int'(Player_X) + PW && int'(Player_X) < int'(Enemy_X) + EW
        && int'(Enemy_Y) < int'(Player_Y) + PH && int'(Player_Y) < int'(Enemy_Y) + EH;
  endfunction

  function automatic logic [16:0] expected();
    return {7'(m_blood), 8'(m_hits), m_cool > 0 && !m_dead, m_dead};
  endfunction

  function automatic logic [16:0] observed();
    return {Player_Blood, Hit_Count, Player_Hurt, Game_Over};
  endfunction

  task automatic model_reset();
    m_blood = 100; m_hits = 0; m_cool = 0; m_streak = 0; m_regen = 0; m_dead = 0;
  endtask

  // One game frame: cooldown counts down remaining frames, contact builds a streak.
  task automatic model_tick();
    bit c = ref_contact();
    if (m_dead) return;
    if (m_cool > 0) begin
      m_cool--; m_streak = 0; m_regen = 0;
    end else if (c) begin
      m_regen = 0;
      m_streak++;
      if (m_streak == 2) begin
        m_streak = 0;
        m_blood = (m_blood > 10) ? m_blood - 10 : 0;
        m_hits = (m_hits < 255) ? m_hits + 1 : 255;
        if (m_blood == 0) m_dead = 1; else m_cool = 30;
      end
    end else begin
      m_streak = 0;
`ifdef PLAYER_REGEN_EN
      if (m_blood < 100) begin
        m_regen++;
        if (m_regen == 60) begin m_blood++; m_regen = 0; end
      end else m_regen = 0;
`endif
    end
  endtask

  task automatic frame(input int px, input int py, input int ex, input int ey, input bit al);
    Player_X = 9'(px); Player_Y = 9'(py); Enemy_X = 9'(ex); Enemy_Y = 9'(ey); Enemy_Alive = al;
    model_tick();
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (observed() !== {7'd100, 8'd0, 1'b0, 1'b0})
      $display("FAIL reset: got blood=%0d hits=%0d hurt=%0b over=%0b, want 100/0/0/0", Player_Blood, Hit_Count, Player_Hurt, Game_Over);
    else passed++;
  endtask

  task automatic test_overlap();
    do_reset();
    for (int t = 1; t <= 100; t++) begin
      frame(100, 100, 110, 110, 1);
      checks++;
      if (observed() !== expected())
        $display("FAIL overlap tick %0d: got %h want %h", t, observed(), expected());
      else passed++;
    end
    checks++;
    if (Player_Blood !== 7'd60 || Hit_Count !== 8'd4)
      $display("FAIL overlap_total: got blood=%0d hits=%0d want 60/4", Player_Blood, Hit_Count);
    else passed++;
  endtask

  task automatic test_edge();
    do_reset();
    for (int t = 0; t < 50; t++) frame(100, 100, 126, 100, 1);
    checks++;
    if (Player_Blood !== 7'd100 || Hit_Count !== 8'd0)
      $display("FAIL edge_touch: got blood=%0d hits=%0d want 100/0", Player_Blood, Hit_Count);
    else passed++;
  endtask

  task automatic test_alive_and_gap();
    do_reset();
    for (int t = 0; t < 10; t++) frame(100, 100, 110, 110, 0);
    checks++;
    if (Player_Blood !== 7'd100) $display("FAIL enemy_dead_overlap: got blood=%0d want 100", Player_Blood);
    else passed++;
    frame(100, 100, 110, 110, 1);
    frame(100, 100, 200, 200, 1);
    frame(100, 100, 110, 110, 1);
    checks++;
    if (Player_Blood !== 7'd100) $display("FAIL gap_restart: got blood=%0d want 100", Player_Blood);
    else passed++;
    frame(100, 100, 110, 110, 1);
    checks++;
    if (Player_Blood !== 7'd90 || Player_Hurt !== 1'b1)
      $display("FAIL gap_then_hit: got blood=%0d hurt=%0b want 90/1", Player_Blood, Player_Hurt);
    else passed++;
  endtask

  task automatic test_death();
    int n = 0;
    do_reset();
    while (!m_dead && n < 500) begin
      frame(100, 100, 110, 110, 1);
      n++;
      checks++;
      if (observed() !== expected()) $display("FAIL death_path tick %0d: got %h want %h", n, observed(), expected());
      else passed++;
    end
    checks++;
    if (Player_Blood !== 7'd0 || Game_Over !== 1'b1 || Player_Hurt !== 1'b0 || Hit_Count !== 8'd10)
      $display("FAIL dead_state: got blood=%0d over=%0b hurt=%0b hits=%0d want 0/1/0/10", Player_Blood, Game_Over, Player_Hurt, Hit_Count);
    else passed++;
    for (int t = 0; t < 200; t++) frame(100, 100, 110, 110, 1);
    checks++;
    if (observed() !== {7'd0, 8'd10, 1'b0, 1'b1})
      $display("FAIL dead_hold: got %h want %h", observed(), {7'd0, 8'd10, 1'b0, 1'b1});
    else passed++;
    do_reset();
    checks++;
    if (Player_Blood !== 7'd100 || Game_Over !== 1'b0)
      $display("FAIL dead_reset: got blood=%0d over=%0b want 100/0", Player_Blood, Game_Over);
    else passed++;
  endtask

  task automatic test_reset_on_tick();
    do_reset();
    frame(100, 100, 110, 110, 1);
    frame(100, 100, 110, 110, 1);
    checks++;
    if (Player_Hurt !== 1'b1) $display("FAIL pre_reset_cooldown: got hurt=%0b want 1", Player_Hurt);
    else passed++;
    frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    checks++;
    if (observed() !== {7'd100, 8'd0, 1'b0, 1'b0})
      $display("FAIL reset_on_tick: got %h want %h", observed(), {7'd100, 8'd0, 1'b0, 1'b0});
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      frame(int'($urandom_range(100, 140)), int'($urandom_range(100, 140)),
            int'($urandom_range(80, 160)), int'($urandom_range(80, 160)), $urandom_range(0, 7) != 0);
      checks++;
      if (observed() !== expected()) $display("FAIL random tick %0d: got %h want %h", t, observed(), expected());
      else passed++;
    end
  endtask

`ifdef PLAYER_REGEN_EN
  task automatic test_regen();
    do_reset();
    frame(100, 100, 110, 110, 1);
    frame(100, 100, 110, 110, 1);
    for (int t = 0; t < 30; t++) frame(100, 100, 300, 300, 1);
    for (int t = 0; t < 60; t++) frame(100, 100, 300, 300, 1);
    checks++;
    if (Player_Blood !== 7'd91 || observed() !== expected())
      $display("FAIL regen: got blood=%0d want 91", Player_Blood);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_overlap();
    test_edge();
    test_alive_and_gap();
    test_death();
    test_reset_on_tick();
    test_random();
`ifdef PLAYER_REGEN_EN
    test_regen();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
